// File: rtl/m3_sopc_pio_arbiter_if.sv
// Bundle of the master-side and slave-side Avalon-MM signals around the PIO arbiter.
// The arbiter uses the slave modport; the environment uses the master modport.
interface m3_sopc_pio_arbiter_if #(
   parameter int N_MASTERS = 2,
   parameter int ADDR_W    = 2,
   parameter int DATA_W    = 32
);
   logic [N_MASTERS*ADDR_W-1:0] m_address;
   logic [N_MASTERS-1:0]        m_read;
   logic [N_MASTERS-1:0]        m_write;
   logic [N_MASTERS*DATA_W-1:0] m_writedata;
   logic [N_MASTERS-1:0]        m_waitrequest;
   logic [DATA_W-1:0]           m_readdata;
   logic [N_MASTERS-1:0]        m_readdatavalid;
   logic [ADDR_W-1:0]           s_address;
   logic                        s_read;
   logic                        s_write;
   logic [DATA_W-1:0]           s_writedata;
   logic [DATA_W-1:0]           s_readdata;

   modport slave (
      input  m_address, m_read, m_write, m_writedata, s_readdata,
      output m_waitrequest, m_readdata, m_readdatavalid,
             s_address, s_read, s_write, s_writedata
   );

   modport master (
      output m_address, m_read, m_write, m_writedata, s_readdata,
      input  m_waitrequest, m_readdata, m_readdatavalid,
             s_address, s_read, s_write, s_writedata
   );
endinterface

// File: rtl/m3_sopc_pio_arbiter.sv
// Round-robin arbiter sharing one fixed-latency (1 cycle) PIO register slave
// between up to four Avalon-MM masters, one transaction in flight at a time.
module m3_sopc_pio_arbiter #(
   parameter int N_MASTERS = 2,
   parameter int ADDR_W    = 2,
   parameter int DATA_W    = 32
) (
   input  logic                    clk,
   input  logic                    reset_n,
   m3_sopc_pio_arbiter_if.slave    bus
);
   // N_MASTERS is limited to 2..4, so a 2-bit index always suffices.
   localparam int IDX_W = (N_MASTERS > 2) ? 2 : 1;

   typedef enum logic [1:0] {IDLE, GRANT, RDATA} state_t;

   state_t               state_q, state_d;
   logic [IDX_W-1:0]     g_q, g_d;
   logic [IDX_W-1:0]     ptr_q, ptr_d;
   logic [IDX_W-1:0]     g_sel, ptr_sel, pick_idx;
   logic                 pick_found;
   logic [N_MASTERS-1:0] req;
   logic [N_MASTERS-1:0] grant_oh;
   logic [N_MASTERS-1:0] wait_req;
   logic [N_MASTERS-1:0] rvalid_q, rvalid_d;
   logic [DATA_W-1:0]    rdata_q, rdata_d;

   assign req = bus.m_read | bus.m_write;

   // Out-of-range codes cannot occur; fold them so master 0 is selected/searched first.
   assign g_sel   = (int'(g_q) < N_MASTERS) ? g_q : '0;
   assign ptr_sel = (int'(ptr_q) < N_MASTERS) ? ptr_q : IDX_W'(N_MASTERS - 1);

   generate
      for (genvar gi = 0; gi < N_MASTERS; gi++) begin : g_decode
         assign grant_oh[gi] = (int'(g_sel) == gi);
         assign wait_req[gi] = !((state_q == GRANT) && grant_oh[gi]);
      end
   endgenerate

   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      for (int k = 1; k <= N_MASTERS; k++) begin
         if (!pick_found && req[(int'(ptr_sel) + k) % N_MASTERS]) begin
            pick_found = 1'b1;
            pick_idx   = IDX_W'((int'(ptr_sel) + k) % N_MASTERS);
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      g_d      = g_q;
      ptr_d    = ptr_q;
      rvalid_d = '0;
      rdata_d  = rdata_q;
      case (state_q)
         IDLE: begin
            if (pick_found) begin
               g_d     = pick_idx;
               ptr_d   = pick_idx;
               state_d = GRANT;
            end
         end
         GRANT: begin
            // A dropped request is treated like a completed write.
            state_d = bus.m_read[g_sel] ? RDATA : IDLE;
         end
         RDATA: begin
            rdata_d  = bus.s_readdata;
            rvalid_d = grant_oh;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.s_address   = '0;
      bus.s_writedata = '0;
      bus.s_read      = 1'b0;
      bus.s_write     = 1'b0;
      if (state_q == GRANT) begin
         bus.s_address   = bus.m_address[int'(g_sel)*ADDR_W +: ADDR_W];
         bus.s_writedata = bus.m_writedata[int'(g_sel)*DATA_W +: DATA_W];
         bus.s_read      = bus.m_read[g_sel];
         bus.s_write     = bus.m_write[g_sel] & ~bus.m_read[g_sel];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         g_q      <= '0;
         ptr_q    <= IDX_W'(N_MASTERS - 1);
         rvalid_q <= '0;
         rdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         g_q      <= g_d;
         ptr_q    <= ptr_d;
         rvalid_q <= rvalid_d;
         rdata_q  <= rdata_d;
      end
   end

   assign bus.m_waitrequest   = wait_req;
   assign bus.m_readdatavalid = rvalid_q;
   assign bus.m_readdata      = rdata_q;
endmodule

// File: tb/tb_m3_sopc_pio_arbiter.sv
// Self-checking bench for m3_sopc_pio_arbiter with four masters: directed
// scenarios plus randomized traffic against a transaction-level reference model.
module tb_m3_sopc_pio_arbiter;
   localparam int N    = 4;
   localparam int AW   = 2;
   localparam int DW   = 32;
   localparam int MAXC = 400;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   errors = 0;
   int   checks = 0;
   int   obs_grants[$];
   logic [DW-1:0] slave_mem [4];

   always #5 clk = ~clk;

   m3_sopc_pio_arbiter_if #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

   m3_sopc_pio_arbiter #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   // Register slave with one cycle of read latency.
   always @(posedge clk) begin
      if (bus.s_write) slave_mem[bus.s_address] = bus.s_writedata;
      if (bus.s_read) bus.s_readdata <= slave_mem[bus.s_address];
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, got no end expected $finish");
      $fatal(1);
   end

   task automatic set_master(input int i, input logic rd, input logic wr,
                             input logic [AW-1:0] a, input logic [DW-1:0] d);
      bus.m_read[i]  = rd;
      bus.m_write[i] = wr;
      bus.m_address[i*AW +: AW]   = a;
      bus.m_writedata[i*DW +: DW] = d;
   endtask

   task automatic clear_masters();
      bus.m_read      = '0;
      bus.m_write     = '0;
      bus.m_address   = '0;
      bus.m_writedata = '0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      clear_masters();
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      next_cycle();
   endtask

   task automatic test_reset();
      clear_masters();
      reset_n = 1'b0;
      for (int i = 0; i < N; i++) set_master(i, 1'b1, 1'b0, AW'(i + 1), 32'hFFFF0000 | DW'(i + 1));
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++; if (bus.m_waitrequest !== 4'hF) begin errors++; $display("FAIL reset_wait got=%h exp=%h", bus.m_waitrequest, 4'hF); end
      checks++; if (bus.m_readdatavalid !== 4'h0) begin errors++; $display("FAIL reset_rvalid got=%h exp=0", bus.m_readdatavalid); end
      checks++; if (bus.m_readdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", bus.m_readdata); end
      checks++; if (bus.s_read !== 1'b0 || bus.s_write !== 1'b0) begin errors++; $display("FAIL reset_strobes got rd=%b wr=%b exp 0 0", bus.s_read, bus.s_write); end
      checks++; if (bus.s_address !== 2'd0 || bus.s_writedata !== 32'h0) begin errors++; $display("FAIL reset_sbus got a=%h d=%h exp 0 0", bus.s_address, bus.s_writedata); end
      reset_n = 1'b1;
      next_cycle();
      @(negedge clk);
      checks++; if (bus.m_waitrequest !== 4'b1110) begin errors++; $display("FAIL reset_first_grant got=%b exp=1110", bus.m_waitrequest); end
      $display("txn reset: first grant with all masters requesting");
      clear_masters();
      repeat (3) next_cycle();
   endtask

   task automatic test_single_read();
      do_reset();
      slave_mem[0] = 32'h20220315;
      set_master(0, 1'b1, 1'b0, 2'd0, 32'h0);
      @(negedge clk);
      checks++; if (bus.m_waitrequest !== 4'hF) begin errors++; $display("FAIL single_rd_c0_wait got=%b exp=1111", bus.m_waitrequest); end
      next_cycle(); @(negedge clk);
      checks++; if (bus.m_waitrequest !== 4'b1110) begin errors++; $display("FAIL single_rd_c1_wait got=%b exp=1110", bus.m_waitrequest); end
      checks++; if (bus.s_read !== 1'b1 || bus.s_write !== 1'b0) begin errors++; $display("FAIL single_rd_c1_strobe got rd=%b wr=%b exp 1 0", bus.s_read, bus.s_write); end
      checks++; if (bus.s_address !== 2'd0) begin errors++; $display("FAIL single_rd_c1_addr got=%h exp=0", bus.s_address); end
      next_cycle(); clear_masters(); @(negedge clk);
      checks++; if (bus.s_read !== 1'b0) begin errors++; $display("FAIL single_rd_c2_sread got=%b exp=0", bus.s_read); end
      checks++; if (bus.m_readdatavalid !== 4'h0) begin errors++; $display("FAIL single_rd_c2_rvalid got=%b exp=0000", bus.m_readdatavalid); end
      next_cycle(); @(negedge clk);
      checks++; if (bus.m_readdatavalid !== 4'b0001) begin errors++; $display("FAIL single_rd_c3_rvalid got=%b exp=0001", bus.m_readdatavalid); end
      checks++; if (bus.m_readdata !== 32'h20220315) begin errors++; $display("FAIL single_rd_c3_rdata got=%h exp=20220315", bus.m_readdata); end
      next_cycle(); @(negedge clk);
      checks++; if (bus.m_readdatavalid !== 4'h0) begin errors++; $display("FAIL single_rd_c4_rvalid got=%b exp=0000", bus.m_readdatavalid); end
      checks++; if (bus.m_readdata !== 32'h20220315) begin errors++; $display("FAIL single_rd_hold got=%h exp=20220315", bus.m_readdata); end
      $display("txn single read: master 0 addr 0");
   endtask

   task automatic test_write();
      do_reset();
      set_master(1, 1'b0, 1'b1, 2'd2, 32'hA5A50001);
      next_cycle(); @(negedge clk);
      checks++; if (bus.m_waitrequest !== 4'b1101) begin errors++; $display("FAIL write_c1_wait got=%b exp=1101", bus.m_waitrequest); end
      checks++; if (bus.s_write !== 1'b1 || bus.s_read !== 1'b0) begin errors++; $display("FAIL write_c1_strobe got wr=%b rd=%b exp 1 0", bus.s_write, bus.s_read); end
      checks++; if (bus.s_address !== 2'd2 || bus.s_writedata !== 32'hA5A50001) begin errors++; $display("FAIL write_c1_bus got a=%h d=%h exp 2 a5a50001", bus.s_address, bus.s_writedata); end
      next_cycle(); clear_masters(); set_master(0, 1'b1, 1'b0, 2'd2, 32'h0); @(negedge clk);
      checks++; if (bus.s_write !== 1'b0 || bus.m_readdatavalid !== 4'h0) begin errors++; $display("FAIL write_c2 got wr=%b rv=%b exp 0 0000", bus.s_write, bus.m_readdatavalid); end
      next_cycle(); @(negedge clk);
      checks++; if (bus.m_waitrequest !== 4'b1110) begin errors++; $display("FAIL write_idle_c2 got=%b exp=1110", bus.m_waitrequest); end
      checks++; if (bus.m_readdatavalid !== 4'h0) begin errors++; $display("FAIL write_c3_rvalid got=%b exp=0000", bus.m_readdatavalid); end
      next_cycle(); clear_masters();
      next_cycle(); @(negedge clk);
      checks++; if (bus.m_readdatavalid !== 4'b0001 || bus.m_readdata !== 32'hA5A50001) begin errors++; $display("FAIL write_readback got rv=%b d=%h exp 0001 a5a50001", bus.m_readdatavalid, bus.m_readdata); end
      $display("txn write: master 1 addr 2 then readback by master 0");
   endtask

   task automatic test_both_strobes();
      do_reset();
      slave_mem[1] = 32'h12345678;
      set_master(0, 1'b1, 1'b1, 2'd1, 32'hDEADBEEF);
      next_cycle(); @(negedge clk);
      checks++; if (bus.s_read !== 1'b1 || bus.s_write !== 1'b0) begin errors++; $display("FAIL both_strobe got rd=%b wr=%b exp 1 0", bus.s_read, bus.s_write); end
      checks++; if (bus.s_address !== 2'd1) begin errors++; $display("FAIL both_addr got=%h exp=1", bus.s_address); end
      next_cycle(); clear_masters();
      next_cycle(); @(negedge clk);
      checks++; if (bus.m_readdatavalid !== 4'b0001 || bus.m_readdata !== 32'h12345678) begin errors++; $display("FAIL both_data got rv=%b d=%h exp 0001 12345678", bus.m_readdatavalid, bus.m_readdata); end
      $display("txn read+write strobes: master 0 addr 1");
   endtask

   task automatic test_dropped();
      do_reset();
      set_master(0, 1'b1, 1'b0, 2'd3, 32'h0);
      next_cycle(); clear_masters(); @(negedge clk);
      checks++; if (bus.s_read !== 1'b0 || bus.s_write !== 1'b0) begin errors++; $display("FAIL drop_strobes got rd=%b wr=%b exp 0 0", bus.s_read, bus.s_write); end
      next_cycle(); set_master(2, 1'b1, 1'b0, 2'd0, 32'h0); @(negedge clk);
      checks++; if (bus.m_readdatavalid !== 4'h0 || bus.m_waitrequest !== 4'hF) begin errors++; $display("FAIL drop_c2 got rv=%b wait=%b exp 0000 1111", bus.m_readdatavalid, bus.m_waitrequest); end
      next_cycle(); @(negedge clk);
      checks++; if (bus.m_readdatavalid !== 4'h0) begin errors++; $display("FAIL drop_no_rvalid got=%b exp=0000", bus.m_readdatavalid); end
      checks++; if (bus.m_waitrequest !== 4'b1011) begin errors++; $display("FAIL drop_next_grant got=%b exp=1011", bus.m_waitrequest); end
      next_cycle(); clear_masters();
      next_cycle(); @(negedge clk);
      checks++; if (bus.m_readdatavalid !== 4'b0100) begin errors++; $display("FAIL drop_after_rvalid got=%b exp=0100", bus.m_readdatavalid); end
      $display("txn dropped read: master 0, followed by master 2 read");
   endtask

   // Drives per-master request streams and checks every cycle against a
   // transaction-level model: round-robin choice plus fixed read/write durations.
   task automatic run_traffic(input int ncyc, input logic [N-1:0] mask,
                              input bit reads_only, input int max_gap);
      int            exp_grant [MAXC];
      int            exp_rv    [MAXC];
      logic          exp_sr    [MAXC];
      logic          exp_sw    [MAXC];
      logic [AW-1:0] exp_addr  [MAXC];
      logic [DW-1:0] exp_wd    [MAXC];
      logic [DW-1:0] exp_rd    [MAXC];
      logic [DW-1:0] model_mem [4];
      logic          pend [N];
      logic          rd   [N];
      logic          wr   [N];
      logic [AW-1:0] ad   [N];
      logic [DW-1:0] wd   [N];
      int            gap  [N];
      int            free_c, ptr, g, t;
      logic [N-1:0]  accepted, exp_wait, exp_rvm;
      do_reset();
      obs_grants.delete();
      for (int a = 0; a < 4; a++) begin
         model_mem[a] = $urandom;
         slave_mem[a] = model_mem[a];
      end
      for (int c = 0; c < MAXC; c++) begin
         exp_grant[c] = -1;
         exp_rv[c]    = -1;
      end
      for (int i = 0; i < N; i++) begin
         pend[i] = 1'b0; rd[i] = 1'b0; wr[i] = 1'b0; ad[i] = '0; wd[i] = '0; gap[i] = 0;
      end
      free_c = 0;
      ptr    = N - 1;
      for (int c = 0; c < ncyc; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!pend[i] && mask[i]) begin
               if (gap[i] > 0) gap[i]--;
               else begin
                  t = int'($urandom_range(0, 3));
                  pend[i] = 1'b1;
                  rd[i] = reads_only || (t == 0) || (t == 2);
                  wr[i] = !reads_only && (t != 0);
                  ad[i] = AW'($urandom_range(0, 3));
                  wd[i] = $urandom;
               end
            end
            set_master(i, pend[i] & rd[i], pend[i] & wr[i], ad[i], wd[i]);
         end
         @(negedge clk);
         exp_wait = '1;
         if (exp_grant[c] >= 0) exp_wait[exp_grant[c]] = 1'b0;
         checks++; if (bus.m_waitrequest !== exp_wait) begin errors++; $display("FAIL traffic_wait c=%0d got=%b exp=%b", c, bus.m_waitrequest, exp_wait); end
         if (exp_grant[c] >= 0) begin
            checks++; if (bus.s_read !== exp_sr[c] || bus.s_write !== exp_sw[c]) begin errors++; $display("FAIL traffic_strobe c=%0d got rd=%b wr=%b exp %b %b", c, bus.s_read, bus.s_write, exp_sr[c], exp_sw[c]); end
            checks++; if (bus.s_address !== exp_addr[c]) begin errors++; $display("FAIL traffic_addr c=%0d got=%h exp=%h", c, bus.s_address, exp_addr[c]); end
            if (exp_sw[c]) begin
               checks++; if (bus.s_writedata !== exp_wd[c]) begin errors++; $display("FAIL traffic_wdata c=%0d got=%h exp=%h", c, bus.s_writedata, exp_wd[c]); end
            end
            $display("txn c=%0d master=%0d %s addr=%0d", c, exp_grant[c], exp_sr[c] ? "read" : "write", exp_addr[c]);
         end else begin
            checks++; if (bus.s_read !== 1'b0 || bus.s_write !== 1'b0) begin errors++; $display("FAIL traffic_idle_strobe c=%0d got rd=%b wr=%b exp 0 0", c, bus.s_read, bus.s_write); end
         end
         exp_rvm = '0;
         if (exp_rv[c] >= 0) exp_rvm[exp_rv[c]] = 1'b1;
         checks++; if (bus.m_readdatavalid !== exp_rvm) begin errors++; $display("FAIL traffic_rvalid c=%0d got=%b exp=%b", c, bus.m_readdatavalid, exp_rvm); end
         if (exp_rv[c] >= 0) begin
            checks++; if (bus.m_readdata !== exp_rd[c]) begin errors++; $display("FAIL traffic_rdata c=%0d got=%h exp=%h", c, bus.m_readdata, exp_rd[c]); end
         end
         accepted = ~bus.m_waitrequest;
         for (int i = 0; i < N; i++) if (accepted[i]) obs_grants.push_back(i);
         if (c >= free_c) begin
            g = -1;
            for (int k = 1; k <= N; k++) if (g < 0 && pend[(ptr + k) % N]) g = (ptr + k) % N;
            if (g >= 0) begin
               ptr = g;
               exp_grant[c+1] = g;
               exp_sr[c+1]    = rd[g];
               exp_sw[c+1]    = wr[g] && !rd[g];
               exp_addr[c+1]  = ad[g];
               exp_wd[c+1]    = wd[g];
               if (rd[g]) begin
                  exp_rv[c+3] = g;
                  exp_rd[c+3] = model_mem[ad[g]];
                  free_c = c + 3;
               end else begin
                  model_mem[ad[g]] = wd[g];
                  free_c = c + 2;
               end
            end
         end
         next_cycle();
         for (int i = 0; i < N; i++) begin
            if (accepted[i]) begin
               pend[i] = 1'b0;
               gap[i]  = int'($urandom_range(0, max_gap));
            end
         end
      end
      clear_masters();
      repeat (4) next_cycle();
   endtask

   task automatic test_contention();
      int n0, n1;
      run_traffic(30, 4'b0011, 1'b1, 0);
      n0 = 0; n1 = 0;
      for (int k = 0; k < 8; k++) begin
         checks++;
         if (obs_grants.size() <= k || obs_grants[k] != (k % 2)) begin
            errors++;
            $display("FAIL contention_order k=%0d got=%0d exp=%0d", k, (obs_grants.size() > k) ? obs_grants[k] : -1, k % 2);
         end else if (obs_grants[k] == 0) n0++;
         else n1++;
      end
      checks++; if (n0 != 4 || n1 != 4) begin errors++; $display("FAIL contention_fair got m0=%0d m1=%0d exp 4 4", n0, n1); end
   endtask

   task automatic test_reset_mid_read();
      int got[$];
      int exp_ord[5];
      exp_ord = '{0, 1, 3, 1, 3};
      do_reset();
      slave_mem[2] = 32'hC0FFEE02;
      slave_mem[1] = 32'h0BADF00D;
      set_master(2, 1'b1, 1'b0, 2'd2, 32'h0);
      next_cycle(); next_cycle(); clear_masters();
      next_cycle(); @(negedge clk);
      checks++; if (bus.m_readdatavalid !== 4'b0100 || bus.m_readdata !== 32'hC0FFEE02) begin errors++; $display("FAIL midrst_pre got rv=%b d=%h exp 0100 c0ffee02", bus.m_readdatavalid, bus.m_readdata); end
      set_master(1, 1'b1, 1'b0, 2'd1, 32'h0);
      next_cycle(); @(negedge clk);
      checks++; if (bus.m_waitrequest !== 4'b1101) begin errors++; $display("FAIL midrst_grant got=%b exp=1101", bus.m_waitrequest); end
      next_cycle(); clear_masters();
      #2 reset_n = 1'b0;
      #1;
      checks++; if (bus.m_waitrequest !== 4'hF || bus.m_readdatavalid !== 4'h0) begin errors++; $display("FAIL midrst_async got wait=%b rv=%b exp 1111 0000", bus.m_waitrequest, bus.m_readdatavalid); end
      checks++; if (bus.m_readdata !== 32'h0 || bus.s_read !== 1'b0) begin errors++; $display("FAIL midrst_async_data got d=%h rd=%b exp 0 0", bus.m_readdata, bus.s_read); end
      @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         checks++; if (bus.m_readdatavalid !== 4'h0) begin errors++; $display("FAIL midrst_no_rvalid k=%0d got=%b exp=0000", k, bus.m_readdatavalid); end
         next_cycle(); @(negedge clk);
      end
      next_cycle();
      set_master(0, 1'b1, 1'b0, 2'd0, 32'h0);
      set_master(1, 1'b1, 1'b0, 2'd1, 32'h0);
      set_master(3, 1'b1, 1'b0, 2'd3, 32'h0);
      for (int c = 0; c < 40 && got.size() < 5; c++) begin
         @(negedge clk);
         for (int i = 0; i < N; i++) if (!bus.m_waitrequest[i]) got.push_back(i);
         next_cycle();
         if (got.size() >= 1) set_master(0, 1'b0, 1'b0, 2'd0, 32'h0);
      end
      checks++; if (got.size() != 5) begin errors++; $display("FAIL midrst_order_count got=%0d exp=5", got.size()); end
      for (int k = 0; k < 5; k++) begin
         checks++;
         if (got.size() <= k || got[k] != exp_ord[k]) begin
            errors++;
            $display("FAIL midrst_order k=%0d got=%0d exp=%0d", k, (got.size() > k) ? got[k] : -1, exp_ord[k]);
         end
      end
      $display("txn reset mid-read then order 0,1,3,1,3");
      clear_masters();
      repeat (4) next_cycle();
   endtask

   task automatic test_random();
      run_traffic(300, 4'b1111, 1'b0, 3);
   endtask

   initial begin
      clear_masters();
      test_reset();
      test_single_read();
      test_write();
      test_both_strobes();
      test_dropped();
      test_contention();
      test_reset_mid_read();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/m3_sopc_pio_arbiter.md
Name: m3_sopc_pio_arbiter

Overview:
- Round-robin Avalon-MM arbiter that shares one PIO-style register slave (build ID, status and control ports) between up to 4 masters, e.g. the CPU data port and the debug/JTAG master.
- Sits between the masters and the slave inside the SoPC interconnect.
- Allows one transaction in flight at a time.
- Assumes the slave has a fixed read latency of 1 cycle: readdata is registered on the cycle after the address is presented.

Parameters:
- N_MASTERS, 2, number of requesting masters (2..4).
- ADDR_W, 2, slave word-address width.
- DATA_W, 32, data width.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset (decided below).
- m_address  in  N_MASTERS*ADDR_W  flattened master addresses; master i occupies bits [i*ADDR_W +: ADDR_W].
- m_read  in  N_MASTERS  per-master read request.
- m_write  in  N_MASTERS  per-master write request.
- m_writedata  in  N_MASTERS*DATA_W  flattened write data.
- m_waitrequest  out  N_MASTERS  per-master waitrequest.
- m_readdata  out  DATA_W  shared read data bus.
- m_readdatavalid  out  N_MASTERS  one-hot read-data-valid qualifier.
- s_address  out  ADDR_W  slave address.
- s_read  out  1  slave read strobe.
- s_write  out  1  slave write strobe.
- s_writedata  out  DATA_W  slave write data.
- s_readdata  in  DATA_W  slave read data, valid 1 cycle after s_read.

Interface (already decided): reset reset_n, asynchronous, active-low; clock clk.

Behaviour:
- Reset values:
  - state = IDLE.
  - m_waitrequest = all ones.
  - m_readdatavalid = 0.
  - m_readdata = 0.
  - s_read = s_write = 0; s_address and s_writedata = 0.
  - Last-grant pointer = N_MASTERS-1, so master 0 wins first.
- Request: req[i] = m_read[i] | m_write[i]. A master holds its address, data and strobe until it sees waitrequest low.
- IDLE:
  - If any req bit is set, pick the first requester searching from pointer+1 with wrap-around.
  - Register that index as g and update pointer = g.
  - Go to GRANT. If no request, stay in IDLE.
- GRANT (exactly 1 cycle):
  - m_waitrequest[g] = 0; all other bits stay 1.
  - s_address, s_writedata = master g's fields.
  - s_read = m_read[g].
  - s_write = m_write[g] & ~m_read[g]. Read wins if both strobes are high.
  - If a read is issued, go to RDATA. Otherwise (write, or the request was dropped) go to IDLE.
- RDATA (1 cycle):
  - Capture s_readdata into m_readdata.
  - Set m_readdatavalid = onehot(g) on the next clock edge, for 1 cycle.
  - Go to IDLE.
- m_waitrequest is decoded only from the registered state and g. There is no combinational path from m_* inputs to m_waitrequest.
- Latency (IDLE sample = cycle 0):
  - GRANT / waitrequest low at cycle 1.
  - Slave data at cycle 2.
  - m_readdatavalid at cycle 3.
  - A write completes at cycle 1.
- Throughput:
  - A read occupies 3 cycles; a write occupies 2 cycles.
  - The IDLE cycle that coincides with readdatavalid may already arbitrate the next request.
- m_readdata holds its last value between valid pulses.
- A request arriving during GRANT or RDATA waits for the next IDLE.
- Simultaneous requests: serviced strictly round-robin. No master waits longer than N_MASTERS-1 other transactions.
- Asynchronous reset in any state returns immediately to the reset values. Any read in flight is discarded with no readdatavalid.
- A pointer or index value at or above N_MASTERS is unreachable. The RTL must handle it by defaulting to master 0.

Test Plan:
- Single read: master 0 reads address 0 while s_readdata = 0x20220315 → m_waitrequest[0] low in cycle 1, s_read high for 1 cycle, m_readdatavalid = 2'b01 and m_readdata = 0x20220315 in cycle 3.
- Contention: masters 0 and 1 hold reads continuously → grants alternate 0,1,0,1; each readdatavalid carries the correct one-hot bit; no master is starved over 8 transactions.
- Write: master 1 writes 0xA5A5_0001 to address 2 → s_write high for exactly 1 cycle with s_address = 2 and that data; no readdatavalid; IDLE in cycle 2.
- Read and write both high: master 0 asserts both strobes → s_read = 1, s_write = 0, data returned normally.
- Dropped request: master 0's read drops before GRANT → s_read = 0, no readdatavalid, back to IDLE.
- Reset mid-read: reset_n pulsed low in RDATA → all outputs return to reset values, no readdatavalid, next grant goes to master 0. With N_MASTERS = 4 and requests only on masters 1 and 3, the grant order is 1,3,1,3.
